alu_8bit_core: RTL and testbench

//   Registered 4-function integer ALU: ADD, SUB, AND, OR on two WIDTH-bit operands.
//   A 2-bit opcode selects the function.

---
 rtl/alu_8bit_core.sv | 121 ++++++++++++
 tb/tb_alu_8bit_core.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_8bit_core.sv
// -----------------------------------------------------------------------------
// alu_8bit_core
//   Registered 4-function integer ALU (ADD, SUB, AND, OR) with one register
//   stage. The result and the C/Z/N/V flags appear one clock after the
//   operands are presented with in_valid=1. With in_valid=0 the result and
//   flags hold their values and out_valid drops.
//
// Ports
//   clk        in   1      clock; all state updates on the rising edge
//   rst        in   1      synchronous, active-high reset (beats in_valid)
//   a          in   WIDTH  operand A
//   b          in   WIDTH  operand B
//   op         in   2      00 ADD, 01 SUB, 10 AND, 11 OR
//   in_valid   in   1      operands/op valid this cycle
//   f          out  WIDTH  registered result
//   carry      out  1      ADD carry-out / SUB borrow / 0 for logic ops
//   zero       out  1      f == 0
//   negative   out  1      f[WIDTH-1]
//   overflow   out  1      signed overflow for ADD/SUB / 0 for logic ops
//   out_valid  out  1      f and flags hold a new result this cycle
// -----------------------------------------------------------------------------
module alu_8bit_core #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [1:0]       op,
   input  logic             in_valid,
   output logic [WIDTH-1:0] f,
   output logic             carry,
   output logic             zero,
   output logic             negative,
   output logic             overflow,
   output logic             out_valid
);

   localparam int MSB = WIDTH - 1;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_AND = 2'b10;
   localparam logic [1:0] OP_OR  = 2'b11;

   // One extra bit on both paths: bit WIDTH of the sum is the carry-out,
   // bit WIDTH of the difference is the borrow (set exactly when a < b).
   logic [WIDTH:0]   sum_w;
   logic [WIDTH:0]   diff_w;

   logic [WIDTH-1:0] f_d;
   logic             carry_d;
   logic             overflow_d;

   logic [WIDTH-1:0] f_q;
   logic             carry_q;
   logic             zero_q;
   logic             negative_q;
   logic             overflow_q;
   logic             out_valid_q;

   assign sum_w  = {1'b0, a} + {1'b0, b};
   assign diff_w = {1'b0, a} - {1'b0, b};

   always_comb begin
      f_d        = '0;
      carry_d    = 1'b0;
      overflow_d = 1'b0;
      unique case (op)
         OP_ADD: begin
            f_d        = sum_w[MSB:0];
            carry_d    = sum_w[WIDTH];
            // Same-sign operands producing a result of the other sign.
            overflow_d = (a[MSB] == b[MSB]) && (sum_w[MSB] != a[MSB]);
         end
         OP_SUB: begin
            f_d        = diff_w[MSB:0];
            carry_d    = diff_w[WIDTH];
            // Opposite-sign operands where the result's sign departs from a.
            overflow_d = (a[MSB] != b[MSB]) && (diff_w[MSB] != a[MSB]);
         end
         OP_AND: f_d = a & b;
         OP_OR:  f_d = a | b;
         default: begin
            f_d        = '0;
            carry_d    = 1'b0;
            overflow_d = 1'b0;
         end
      endcase
   end

   // The result registers load only on in_valid, so unknown operands on
   // idle cycles can never reach the outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         f_q         <= '0;
         carry_q     <= 1'b0;
         zero_q      <= 1'b1;
         negative_q  <= 1'b0;
         overflow_q  <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         out_valid_q <= in_valid;
         if (in_valid) begin
            f_q        <= f_d;
            carry_q    <= carry_d;
            zero_q     <= (f_d == '0);
            negative_q <= f_d[MSB];
            overflow_q <= overflow_d;
         end
      end
   end

   assign f         = f_q;
   assign carry     = carry_q;
   assign zero      = zero_q;
   assign negative  = negative_q;
   assign overflow  = overflow_q;
   assign out_valid = out_valid_q;

endmodule

// File: tb/tb_alu_8bit_core.sv
// -----------------------------------------------------------------------------
// tb_alu_8bit_core
//   Self-checking bench for alu_8bit_core (WIDTH=8). Directed scenarios check
//   against literal expected vectors; the random scenario checks against an
//   arithmetic reference model built from plain integer math.
//   Observed/expected vectors are packed as
//   {f[7:0], carry, zero, negative, overflow, out_valid}.
// -----------------------------------------------------------------------------
module tb_alu_8bit_core;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic [1:0]   op;
   logic         in_valid;
   logic [W-1:0] f;
   logic         carry;
   logic         zero;
   logic         negative;
   logic         overflow;
   logic         out_valid;

   int n_checks = 0;
   int n_fail   = 0;

   // Model of what the outputs should be after the most recent edge.
   logic [W+4:0] exp_vec;
   logic [W+4:0] obs_vec;

   alu_8bit_core #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .a         (a),
      .b         (b),
      .op        (op),
      .in_valid  (in_valid),
      .f         (f),
      .carry     (carry),
      .zero      (zero),
      .negative  (negative),
      .overflow  (overflow),
      .out_valid (out_valid)
   );

   always #5 clk = ~clk;

   assign obs_vec = {f, carry, zero, negative, overflow, out_valid};

   // Reference result from integer arithmetic: {f, carry, zero, neg, ovf}.
   function automatic logic [W+3:0] ref_alu(input int ua, input int ub, input int opc);
      int sa, sb, r, sr, fr;
      logic c, v;
      sa = (ua >= 128) ? ua - 256 : ua;
      sb = (ub >= 128) ? ub - 256 : ub;
      c  = 1'b0;
      v  = 1'b0;
      case (opc)
         0: begin r = ua + ub; sr = sa + sb; c = (r > 255);  v = (sr > 127) || (sr < -128); end
         1: begin r = ua - ub; sr = sa - sb; c = (ua < ub);  v = (sr > 127) || (sr < -128); end
         2: r = ua & ub;
         default: r = ua | ub;
      endcase
      fr = ((r % 256) + 256) % 256;
      ref_alu = {fr[W-1:0], c, (fr == 0), (fr >= 128), v};
   endfunction

   // Apply one cycle of inputs, advance past the edge, update the model.
   task automatic drive_cycle(input logic r, input logic v, input logic [W-1:0] av,
                              input logic [W-1:0] bv, input logic [1:0] opv);
      rst      = r;
      in_valid = v;
      a        = av;
      b        = bv;
      op       = opv;
      @(posedge clk);
      #1;
      if (r)
         exp_vec = {8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      else if (v)
         exp_vec = {ref_alu(int'(av), int'(bv), int'(opv)), 1'b1};
      else
         exp_vec[0] = 1'b0;
   endtask

   task automatic test_reset();
      drive_cycle(1'b1, 1'b0, 8'h00, 8'h00, 2'b00);
      drive_cycle(1'b1, 1'b0, 8'h00, 8'h00, 2'b00);
      n_checks++;
      if (obs_vec !== {8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
         n_fail++;
         $display("FAIL reset: got %h want %h", obs_vec, {8'h00, 5'b01000});
      end
   endtask

   task automatic test_op_sweep();
      logic [W-1:0] want_f [4];
      want_f = '{8'h1B, 8'h19, 8'h00, 8'h1B};
      for (int i = 0; i < 4; i++) begin
         drive_cycle(1'b0, 1'b1, 8'h1A, 8'h01, 2'(i));
         n_checks++;
         if ({f, zero, out_valid} !== {want_f[i], (i == 2), 1'b1}) begin
            n_fail++;
            $display("FAIL op_sweep op=%0d: got f=%h z=%b ov=%b want f=%h z=%b ov=1",
                     i, f, zero, out_valid, want_f[i], (i == 2));
         end
      end
   endtask

   task automatic test_carry_wrap();
      drive_cycle(1'b0, 1'b1, 8'hFF, 8'h01, 2'b00);
      n_checks++;
      if (obs_vec !== {8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1}) begin
         n_fail++;
         $display("FAIL add_wrap: got %h want %h", obs_vec, {8'h00, 5'b11001});
      end
      drive_cycle(1'b0, 1'b1, 8'h00, 8'h01, 2'b01);
      n_checks++;
      if (obs_vec !== {8'hFF, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1}) begin
         n_fail++;
         $display("FAIL sub_borrow: got %h want %h", obs_vec, {8'hFF, 5'b10101});
      end
   endtask

   task automatic test_overflow();
      drive_cycle(1'b0, 1'b1, 8'h7F, 8'h01, 2'b00);
      n_checks++;
      if (obs_vec !== {8'h80, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1}) begin
         n_fail++;
         $display("FAIL add_ovf: got %h want %h", obs_vec, {8'h80, 5'b00111});
      end
      drive_cycle(1'b0, 1'b1, 8'h80, 8'h01, 2'b01);
      n_checks++;
      if (obs_vec !== {8'h7F, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1}) begin
         n_fail++;
         $display("FAIL sub_ovf: got %h want %h", obs_vec, {8'h7F, 5'b00011});
      end
      drive_cycle(1'b0, 1'b1, 8'h10, 8'h20, 2'b00);
      n_checks++;
      if (obs_vec !== {8'h30, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
         n_fail++;
         $display("FAIL add_no_ovf: got %h want %h", obs_vec, {8'h30, 5'b00001});
      end
   endtask

   task automatic test_valid_hold();
      drive_cycle(1'b0, 1'b1, 8'h55, 8'h0F, 2'b11);
      n_checks++;
      if (obs_vec !== {8'h5F, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
         n_fail++;
         $display("FAIL or_result: got %h want %h", obs_vec, {8'h5F, 5'b00001});
      end
      // Idle cycles with unknown operands: outputs hold, no X leaks through.
      for (int i = 0; i < 3; i++) begin
         drive_cycle(1'b0, 1'b0, 'x, 'x, 'x);
         n_checks++;
         if (obs_vec !== {8'h5F, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL hold%0d: got %h want %h", i, obs_vec, {8'h5F, 5'b00000});
         end
      end
      drive_cycle(1'b1, 1'b1, 8'hFF, 8'h01, 2'b00);
      n_checks++;
      if (obs_vec !== {8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
         n_fail++;
         $display("FAIL rst_over_valid: got %h want %h", obs_vec, {8'h00, 5'b01000});
      end
   endtask

   task automatic test_back_to_back();
      drive_cycle(1'b0, 1'b1, 8'hF0, 8'h0F, 2'b10);
      n_checks++;
      if (obs_vec !== {8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1}) begin
         n_fail++;
         $display("FAIL b2b_and: got %h want %h", obs_vec, {8'h00, 5'b01001});
      end
      drive_cycle(1'b0, 1'b1, 8'hC8, 8'h64, 2'b00);
      n_checks++;
      if (obs_vec !== {8'h2C, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1}) begin
         n_fail++;
         $display("FAIL b2b_add: got %h want %h", obs_vec, {8'h2C, 5'b10001});
      end
   endtask

   task automatic test_random();
      int errs = 0;
      for (int i = 0; i < 10000; i++) begin
         logic         v;
         logic         r;
         logic [W-1:0] av, bv;
         logic [1:0]   opv;
         v   = ($urandom_range(0, 3) != 0);
         r   = ($urandom_range(0, 199) == 0);
         av  = W'($urandom);
         bv  = W'($urandom);
         opv = 2'($urandom);
         // Bias toward the interesting edges now and then.
         if ($urandom_range(0, 9) == 0) av = 8'h80;
         if ($urandom_range(0, 9) == 0) bv = 8'hFF;
         drive_cycle(r, v, av, bv, opv);
         n_checks++;
         if (obs_vec !== exp_vec) begin
            n_fail++;
            errs++;
            if (errs <= 10)
               $display("FAIL random[%0d] a=%h b=%h op=%0d v=%b r=%b: got %h want %h",
                        i, av, bv, opv, v, r, obs_vec, exp_vec);
         end
      end
   endtask

   initial begin
      rst      = 1'b1;
      in_valid = 1'b0;
      a        = '0;
      b        = '0;
      op       = '0;
      exp_vec  = '0;
      test_reset();
      test_op_sweep();
      test_carry_wrap();
      test_overflow();
      test_valid_hold();
      test_back_to_back();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
